// File: rtl/lsu_pkg.sv
// Shared types and helpers for the hxd32 load/store unit.
package lsu_op_enum;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    LSU_SIZE_B = 2'd0,
    LSU_SIZE_H = 2'd1,
    LSU_SIZE_W = 2'd2
  } lsu_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_REQ,
    LSU_WAIT
  } lsu_state_t;

  // Rejects halves on odd addresses, words off a word boundary, and size 3.
  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LSU_SIZE_B: lsu_misaligned = 1'b0;
      LSU_SIZE_H: lsu_misaligned = off[0];
      LSU_SIZE_W: lsu_misaligned = (off != 2'b00);
      default:    lsu_misaligned = 1'b1;
    endcase
  endfunction

  // Byte enables for an aligned access.
  function automatic logic [3:0] lsu_be(input logic [1:0] size, input logic [1:0] off);
    case (size)
      LSU_SIZE_B: lsu_be = 4'b0001 << off;
      LSU_SIZE_H: lsu_be = 4'b0011 << off;
      default:    lsu_be = 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the byte enables pick the right copy.
  function automatic logic [31:0] lsu_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      LSU_SIZE_B: lsu_wdata = {4{wd[7:0]}};
      LSU_SIZE_H: lsu_wdata = {2{wd[15:0]}};
      default:    lsu_wdata = wd;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ext.sv
// Load data extraction: selects the addressed lane and sign/zero-extends it.
module lsu_ext
  import lsu_op_enum::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  // Lane select and extension; words pass through unchanged.
  always_comb begin
    b    = word[{off, 3'b000} +: 8];
    h    = off[1] ? word[31:16] : word[15:0];
    data = word;
    case (size)
      LSU_SIZE_B: data = {{24{~is_unsigned & b[7]}}, b};
      LSU_SIZE_H: data = {{16{~is_unsigned & h[15]}}, h};
      default:    data = word;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// hxd32 load/store unit: runs one data-bus transaction per accepted op and
// stalls the pipeline until it completes.
module lsu
  import lsu_op_enum::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_unsigned_i,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic [XLEN-1:0]   lsu_wr_data_i,
  output logic              lsu_busy_o,
  output logic              lsu_done_o,
  output logic [XLEN-1:0]   lsu_rd_data_o,
  output logic              lsu_misalign_o,
  output logic              dbus_req_o,
  output logic              dbus_we_o,
  output logic [XLEN-1:0]   dbus_addr_o,
  output logic [XLEN/8-1:0] dbus_be_o,
  output logic [XLEN-1:0]   dbus_wr_data_o,
  input  logic              dbus_gnt_i,
  input  logic              dbus_rvalid_i,
  input  logic [XLEN-1:0]   dbus_rd_data_i
);

  lsu_state_t  state;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] ext_data;

  // Extraction uses only registered op fields, so the response word reaches
  // lsu_rd_data_o through a flop and never combinationally.
  lsu_ext u_ext (
    .size        (size_q),
    .is_unsigned (uns_q),
    .off         (off_q),
    .word        (dbus_rd_data_i),
    .data        (ext_data)
  );

  assign lsu_busy_o = (state != LSU_IDLE);

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= LSU_IDLE;
      size_q         <= 2'd0;
      uns_q          <= 1'b0;
      off_q          <= 2'd0;
      dbus_req_o     <= 1'b0;
      dbus_we_o      <= 1'b0;
      dbus_addr_o    <= '0;
      dbus_be_o      <= '0;
      dbus_wr_data_o <= '0;
      lsu_done_o     <= 1'b0;
      lsu_misalign_o <= 1'b0;
      lsu_rd_data_o  <= '0;
    end else begin
      lsu_done_o     <= 1'b0;
      lsu_misalign_o <= 1'b0;
      case (state)
        LSU_IDLE: begin
          if (lsu_req_i) begin
            if (lsu_misaligned(lsu_size_i, lsu_addr_i[1:0])) begin
              lsu_misalign_o <= 1'b1;
            end else begin
              size_q         <= lsu_size_i;
              uns_q          <= lsu_unsigned_i;
              off_q          <= lsu_addr_i[1:0];
              dbus_req_o     <= 1'b1;
              dbus_we_o      <= lsu_we_i;
              dbus_addr_o    <= {lsu_addr_i[XLEN-1:2], 2'b00};
              dbus_be_o      <= lsu_be(lsu_size_i, lsu_addr_i[1:0]);
              dbus_wr_data_o <= lsu_wdata(lsu_size_i, lsu_wr_data_i);
              state          <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (dbus_gnt_i) begin
            dbus_req_o <= 1'b0;
            if (dbus_we_o) begin
              lsu_done_o <= 1'b1;
              state      <= LSU_IDLE;
            end else begin
              state <= LSU_WAIT;
            end
          end
        end
        LSU_WAIT: begin
          if (dbus_rvalid_i) begin
            lsu_rd_data_o <= ext_data;
            lsu_done_o    <= 1'b1;
            state         <= LSU_IDLE;
          end
        end
        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with hand-computed expectations.
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        lsu_req_i, lsu_we_i, lsu_unsigned_i;
  logic [1:0]  lsu_size_i;
  logic [31:0] lsu_addr_i, lsu_wr_data_i;
  logic        lsu_busy_o, lsu_done_o, lsu_misalign_o;
  logic [31:0] lsu_rd_data_o;
  logic        dbus_req_o, dbus_we_o;
  logic [31:0] dbus_addr_o, dbus_wr_data_o;
  logic [3:0]  dbus_be_o;
  logic        dbus_gnt_i, dbus_rvalid_i;
  logic [31:0] dbus_rd_data_i;

  int n_tests = 0;
  int n_fail  = 0;

  lsu dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .lsu_req_i      (lsu_req_i),
    .lsu_we_i       (lsu_we_i),
    .lsu_size_i     (lsu_size_i),
    .lsu_unsigned_i (lsu_unsigned_i),
    .lsu_addr_i     (lsu_addr_i),
    .lsu_wr_data_i  (lsu_wr_data_i),
    .lsu_busy_o     (lsu_busy_o),
    .lsu_done_o     (lsu_done_o),
    .lsu_rd_data_o  (lsu_rd_data_o),
    .lsu_misalign_o (lsu_misalign_o),
    .dbus_req_o     (dbus_req_o),
    .dbus_we_o      (dbus_we_o),
    .dbus_addr_o    (dbus_addr_o),
    .dbus_be_o      (dbus_be_o),
    .dbus_wr_data_o (dbus_wr_data_o),
    .dbus_gnt_i     (dbus_gnt_i),
    .dbus_rvalid_i  (dbus_rvalid_i),
    .dbus_rd_data_i (dbus_rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present an op for one cycle; returns in cycle 1 of the transaction.
  task automatic op_start(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
    lsu_we_i = we; lsu_size_i = sz; lsu_unsigned_i = uns;
    lsu_addr_i = a; lsu_wr_data_i = wd; lsu_req_i = 1'b1;
    tick();
    lsu_req_i = 1'b0;
  endtask

  // Zero-wait load: gnt in cycle 1, rvalid in cycle 2, result in cycle 3.
  task automatic load0(input string tag, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] word,
                       input logic [3:0] be_exp, input logic [31:0] rd_exp);
    op_start(1'b0, sz, uns, a, 32'h0);
    chk({tag, "_be"}, {28'h0, dbus_be_o}, {28'h0, be_exp});
    chk({tag, "_req"}, {31'h0, dbus_req_o}, 32'd1);
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    chk({tag, "_wait_req"}, {31'h0, dbus_req_o}, 32'd0);
    dbus_rvalid_i = 1'b1; dbus_rd_data_i = word;
    tick();
    dbus_rvalid_i = 1'b0; dbus_rd_data_i = 32'h0;
    chk({tag, "_done"}, {31'h0, lsu_done_o}, 32'd1);
    chk({tag, "_rd"}, lsu_rd_data_o, rd_exp);
    chk({tag, "_busy"}, {31'h0, lsu_busy_o}, 32'd0);
  endtask

  initial begin
    rst_i = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_size_i = 2'd0;
    lsu_unsigned_i = 1'b0; lsu_addr_i = 32'h0; lsu_wr_data_i = 32'h0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_rd_data_i = 32'h0;
    tick(); tick();
    rst_i = 1'b0;

    // Reset values
    chk("rst_busy", {31'h0, lsu_busy_o}, 32'd0);
    chk("rst_req",  {31'h0, dbus_req_o}, 32'd0);
    chk("rst_addr", dbus_addr_o, 32'h0);
    chk("rst_be",   {28'h0, dbus_be_o}, 32'h0);
    chk("rst_rd",   lsu_rd_data_o, 32'h0);
    chk("rst_done", {31'h0, lsu_done_o}, 32'd0);

    // SW 0xDEADBEEF @0x100, gnt after two wait cycles
    op_start(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) dbus_gnt_i = 1'b1;
      chk("sw_req",  {31'h0, dbus_req_o}, 32'd1);
      chk("sw_addr", dbus_addr_o, 32'h100);
      chk("sw_be",   {28'h0, dbus_be_o}, 32'hF);
      chk("sw_wd",   dbus_wr_data_o, 32'hDEADBEEF);
      chk("sw_we",   {31'h0, dbus_we_o}, 32'd1);
      chk("sw_busy", {31'h0, lsu_busy_o}, 32'd1);
      chk("sw_nodone", {31'h0, lsu_done_o}, 32'd0);
      tick();
    end
    dbus_gnt_i = 1'b0;
    chk("sw_done",  {31'h0, lsu_done_o}, 32'd1);
    chk("sw_busy0", {31'h0, lsu_busy_o}, 32'd0);
    chk("sw_req0",  {31'h0, dbus_req_o}, 32'd0);
    tick();
    chk("sw_done1", {31'h0, lsu_done_o}, 32'd0);

    // LB / LBU from lane 3
    load0("lb",  2'd0, 1'b0, 32'h203, 32'h80FFFF12, 4'b1000, 32'hFFFFFF80);
    load0("lbu", 2'd0, 1'b1, 32'h203, 32'h80FFFF12, 4'b1000, 32'h00000080);

    // SH to upper half, lane replication
    op_start(1'b1, 2'd1, 1'b0, 32'h302, 32'h1234ABCD);
    chk("sh_be",   {28'h0, dbus_be_o}, 32'hC);
    chk("sh_wd",   dbus_wr_data_o, 32'hABCDABCD);
    chk("sh_addr", dbus_addr_o, 32'h300);
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    chk("sh_done", {31'h0, lsu_done_o}, 32'd1);

    load0("lh",  2'd1, 1'b0, 32'h302, 32'h7FFE0000, 4'b1100, 32'h00007FFE);
    load0("lhn", 2'd1, 1'b0, 32'h300, 32'h00008001, 4'b0011, 32'hFFFF8001);

    // Misaligned / illegal ops
    op_start(1'b0, 2'd2, 1'b0, 32'h101, 32'h0);
    chk("mis_lw_pulse", {31'h0, lsu_misalign_o}, 32'd1);
    chk("mis_lw_req",   {31'h0, dbus_req_o}, 32'd0);
    chk("mis_lw_busy",  {31'h0, lsu_busy_o}, 32'd0);
    chk("mis_lw_done",  {31'h0, lsu_done_o}, 32'd0);
    tick();
    chk("mis_lw_clr",   {31'h0, lsu_misalign_o}, 32'd0);
    op_start(1'b0, 2'd1, 1'b0, 32'h103, 32'h0);
    chk("mis_lh_pulse", {31'h0, lsu_misalign_o}, 32'd1);
    chk("mis_lh_req",   {31'h0, dbus_req_o}, 32'd0);
    tick();
    op_start(1'b1, 2'd3, 1'b0, 32'h100, 32'h0);
    chk("mis_sz3_pulse", {31'h0, lsu_misalign_o}, 32'd1);
    chk("mis_sz3_req",   {31'h0, dbus_req_o}, 32'd0);
    chk("mis_sz3_done",  {31'h0, lsu_done_o}, 32'd0);
    tick();
    chk("mis_sz3_req2",  {31'h0, dbus_req_o}, 32'd0);

    // Back-to-back LW then SW
    op_start(1'b0, 2'd2, 1'b0, 32'h200, 32'h0);
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    dbus_rvalid_i = 1'b1; dbus_rd_data_i = 32'h11223344;
    tick();
    dbus_rvalid_i = 1'b0;
    chk("b2b_done1", {31'h0, lsu_done_o}, 32'd1);
    chk("b2b_busy",  {31'h0, lsu_busy_o}, 32'd0);
    chk("b2b_rd",    lsu_rd_data_o, 32'h11223344);
    op_start(1'b1, 2'd2, 1'b0, 32'h204, 32'h55667788);
    chk("b2b_req2",  {31'h0, dbus_req_o}, 32'd1);
    chk("b2b_addr2", dbus_addr_o, 32'h204);
    chk("b2b_we2",   {31'h0, dbus_we_o}, 32'd1);
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    chk("b2b_done2", {31'h0, lsu_done_o}, 32'd1);
    chk("b2b_rdhold", lsu_rd_data_o, 32'h11223344);

    // Reset while waiting for the load response
    op_start(1'b0, 2'd2, 1'b0, 32'h300, 32'h0);
    dbus_gnt_i = 1'b1;
    tick();
    dbus_gnt_i = 1'b0;
    chk("rw_busy_wait", {31'h0, lsu_busy_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rw_busy", {31'h0, lsu_busy_o}, 32'd0);
    chk("rw_req",  {31'h0, dbus_req_o}, 32'd0);
    chk("rw_rd",   lsu_rd_data_o, 32'h0);
    dbus_rvalid_i = 1'b1; dbus_rd_data_i = 32'hCAFEF00D;
    tick();
    dbus_rvalid_i = 1'b0;
    chk("rw_nodone", {31'h0, lsu_done_o}, 32'd0);
    chk("rw_rd2",    lsu_rd_data_o, 32'h0);
    tick();
    chk("rw_nodone2", {31'h0, lsu_done_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit of the hxd32 core, directly downstream of the execute stage: it consumes the ALU result as the effective address and rs2 as store data. It runs a data-bus transaction through a request/grant/response handshake. Store data is lane-aligned with byte enables; load data is extracted and sign- or zero-extended. The block stalls the pipeline while a transaction is outstanding and returns the load result for writeback.

## Interface
- XLEN, 32, data/address width; only 32 is supported.
- clk_i  in  1  core clock.
- rst_i  in  1  reset; one clock, synchronous, active-high.
- lsu_req_i  in  1  memory op valid this cycle; sampled only in IDLE.
- lsu_we_i  in  1  1 = store, 0 = load.
- lsu_size_i  in  2  0 byte, 1 half, 2 word; 3 is illegal.
- lsu_unsigned_i  in  1  zero-extend loads (LBU/LHU).
- lsu_addr_i  in  XLEN  effective address (ALU result).
- lsu_wr_data_i  in  XLEN  store data (rs2).
- lsu_busy_o  out  1  pipeline stall; high whenever state != IDLE.
- lsu_done_o  out  1  one-cycle pulse when an op completes.
- lsu_rd_data_o  out  XLEN  extended load result; holds until the next load completes.
- lsu_misalign_o  out  1  one-cycle pulse: misaligned or illegal op rejected.
- dbus_req_o  out  1  bus request.
- dbus_we_o  out  1  bus write.
- dbus_addr_o  out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00}).
- dbus_be_o  out  XLEN/8  byte enables.
- dbus_wr_data_o  out  XLEN  lane-replicated store data.
- dbus_gnt_i  in  1  request accepted this cycle.
- dbus_rvalid_i  in  1  load response valid; earliest the cycle after gnt.
- dbus_rd_data_i  in  XLEN  load response word.

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE with lsu_req_i: check alignment.
  - Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or size 3.
  - Misaligned: pulse lsu_misalign_o next cycle, stay IDLE, no bus activity, no done pulse.
  - Aligned: register we, size, unsigned, addr[1:0], bus address, be and write data; go to REQ.
- REQ: dbus_req_o=1. dbus_we_o, dbus_addr_o, dbus_be_o and dbus_wr_data_o are held stable until gnt.
  - gnt with a store: pulse done, go to IDLE.
  - gnt with a load: go to WAIT.
- WAIT: dbus_req_o=0. On rvalid, register the extended result into lsu_rd_data_o, pulse done, go to IDLE.
- Byte enables:
  - byte = 4'b0001 << addr[1:0]
  - half = 4'b0011 << addr[1:0]
  - word = 4'b1111
- Store data: byte {4{wd[7:0]}}, half {2{wd[15:0]}}, word wd.
- Load extract: byte lane addr[1:0]*8, half lane addr[1]*16; sign-extend unless lsu_unsigned_i.
- lsu_req_i during busy is ignored; the pipeline holds it stable.
- dbus_rvalid_i in IDLE or REQ is ignored.
- dbus_gnt_i outside REQ is ignored.

## Timing
- All outputs are registered or decoded from state; no combinational path from bus inputs to lsu_* outputs.
- Reset values: state IDLE; dbus_req_o 0, dbus_we_o 0, dbus_addr_o 0, dbus_be_o 0, dbus_wr_data_o 0; lsu_done_o 0, lsu_misalign_o 0, lsu_rd_data_o 0; lsu_busy_o 0.
- Load, zero wait (req@0, gnt@1, rvalid@2): lsu_done_o and lsu_rd_data_o at cycle 3.
- Store, zero wait: gnt@1, lsu_done_o at cycle 2.
- Each gnt delay cycle or rvalid delay cycle adds one cycle to completion.
- lsu_busy_o is high from cycle 1 through the cycle the FSM returns to IDLE. It is low in the done-pulse cycle, so a new request is accepted that cycle (back-to-back ops).
- Reset mid-transaction: next edge returns to IDLE and drops dbus_req_o; no done pulse; a late rvalid is ignored.

## Structure
- Package lsu_op_enum holds:
  - typedef lsu_size_t (LSU_SIZE_B=0, LSU_SIZE_H=1, LSU_SIZE_W=2)
  - typedef lsu_state_t (LSU_IDLE, LSU_REQ, LSU_WAIT)
- One combinational sub-module, lsu_ext: (size, unsigned, addr[1:0], word) -> extended load data.
- Store lane/byte-enable generation stays in lsu.

## Test plan
- Word store 0xDEADBEEF @0x100, gnt after 2 wait cycles -> dbus_be_o=4'b1111, dbus_addr_o 0x100 held 3 cycles, single done pulse, busy low afterwards.
- LB @0x203, bus word 0x80FF_FF12 -> lsu_rd_data_o=0xFFFFFF80; LBU same -> 0x00000080; dbus_be_o=4'b1000.
- SH 0x1234ABCD @0x302 -> be=4'b1100, dbus_wr_data_o=0xABCDABCD; LH @0x302 of 0x7FFE0000 -> 0x00007FFE.
- LW @0x101, LH @0x103, size 3 -> lsu_misalign_o pulse, dbus_req_o never asserted, no done.
- Back-to-back load then store with zero-wait bus -> second request accepted in the first done cycle, dbus_req_o reasserts the next cycle.
- rst_i asserted in WAIT, then rvalid arrives -> state IDLE, dbus_req_o=0, no done pulse, lsu_rd_data_o=0.
